// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 set-2 scan codes and prefix FSM states shared by the operand entry block.
package ps2_pkg;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_D0    = 8'h45;
    localparam logic [7:0] SC_D1    = 8'h16;
    localparam logic [7:0] SC_D2    = 8'h1E;
    localparam logic [7:0] SC_D3    = 8'h26;
    localparam logic [7:0] SC_D4    = 8'h25;
    localparam logic [7:0] SC_D5    = 8'h2E;
    localparam logic [7:0] SC_D6    = 8'h36;
    localparam logic [7:0] SC_D7    = 8'h3D;
    localparam logic [7:0] SC_D8    = 8'h3E;
    localparam logic [7:0] SC_D9    = 8'h46;
    typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK} state_t;
endpackage

// File: rtl/ps2_digit_map.sv
// ps2_digit_map: maps a set-2 scan code to its decimal digit, flagging non-digit codes.
module ps2_digit_map
    import ps2_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic       is_digit,
    output logic [3:0] digit
);
    always_comb begin
        is_digit = 1'b1;
        digit = 4'd0;
        case (scan_code)
            SC_D0: digit = 4'd0;
            SC_D1: digit = 4'd1;
            SC_D2: digit = 4'd2;
            SC_D3: digit = 4'd3;
            SC_D4: digit = 4'd4;
            SC_D5: digit = 4'd5;
            SC_D6: digit = 4'd6;
            SC_D7: digit = 4'd7;
            SC_D8: digit = 4'd8;
            SC_D9: digit = 4'd9;
            default: is_digit = 1'b0;
        endcase
    end
endmodule

// File: rtl/ps2_operand_entry.sv
// ps2_operand_entry: collects packed-BCD operands from a PS/2 scan-code stream with editing,
// typematic-repeat suppression and a done/ack handshake.
module ps2_operand_entry
    import ps2_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int NUM_OPERANDS = 2,
    localparam int OPW  = NUM_DIGITS * 4,
    localparam int IDXW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1,
    localparam int CW   = $clog2(NUM_DIGITS + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scan_valid,
    input  logic [7:0]                  scan_code,
    input  logic                        ack,
    output logic [NUM_OPERANDS*OPW-1:0] operands,
    output logic [IDXW-1:0]             op_idx,
    output logic [CW-1:0]               digit_count,
    output logic                        done,
    output logic                        overflow
);
    localparam logic [CW-1:0]   MAXD = CW'(NUM_DIGITS);
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_OPERANDS - 1);

    state_t          state;
    logic [7:0]      held_code;
    logic [OPW-1:0]  opr [NUM_OPERANDS];
    logic [OPW-1:0]  cur;
    logic            is_digit;
    logic [3:0]      digit;
    logic            make;
    logic            act;
    logic            clr;

    ps2_digit_map u_map (.scan_code(scan_code), .is_digit(is_digit), .digit(digit));

    assign cur  = opr[op_idx];
    assign make = scan_valid && state == ST_IDLE && scan_code != SC_BREAK && scan_code != SC_EXT;
    // a make of the still-held key is typematic repeat and never acts
    assign act  = make && scan_code != held_code && !done;
    assign clr  = (done && ack) || (act && scan_code == SC_ESC);

    for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_out
        assign operands[g*OPW +: OPW] = opr[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            held_code <= '0;
            op_idx <= '0;
            digit_count <= '0;
            done <= 1'b0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_OPERANDS; i++) opr[i] <= '0;
        end else begin
            overflow <= 1'b0;
            if (scan_valid) begin
                state <= state == ST_BRK ? ST_IDLE :
                         scan_code == SC_BREAK ? ST_BRK :
                         state == ST_IDLE && scan_code == SC_EXT ? ST_EXT : ST_IDLE;
                if (state == ST_BRK && scan_code == held_code) held_code <= '0;
            end
            if (make) held_code <= scan_code;
            if (clr) begin
                for (int i = 0; i < NUM_OPERANDS; i++) opr[i] <= '0;
                op_idx <= '0;
                digit_count <= '0;
                done <= 1'b0;
            end else if (act) begin
                if (is_digit) begin
                    if (digit_count < MAXD) begin
                        opr[op_idx] <= (cur << 4) | OPW'(digit);
                        digit_count <= digit_count + 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else if (scan_code == SC_BKSP && digit_count != '0) begin
                    opr[op_idx] <= cur >> 4;
                    digit_count <= digit_count - 1'b1;
                end else if (scan_code == SC_ENTER && digit_count != '0) begin
                    if (op_idx == LAST) begin
                        done <= 1'b1;
                    end else begin
                        op_idx <= op_idx + 1'b1;
                        digit_count <= '0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_ps2_operand_entry.sv
// tb_ps2_operand_entry: drives a 4x2 and an 8x3 instance with the same scan stream and checks
// both against a digit-list reference model plus fixed expectations for the directed scenarios.
module tb_ps2_operand_entry;
    logic        clk = 1'b0;
    logic        rst;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        ack;
    logic [31:0] ops_a;
    logic [0:0]  idx_a;
    logic [2:0]  cnt_a;
    logic        done_a, ov_a;
    logic [95:0] ops_b;
    logic [1:0]  idx_b;
    logic [3:0]  cnt_b;
    logic        done_b, ov_b;

    int tests = 0;
    int failed = 0;
    int ov_cnt = 0;

    logic [31:0] mval [2][4];
    int mcnt [2], midx [2], mheld [2], mpre [2];
    bit mdone [2], mov [2];
    int nd [2] = '{4, 8};
    int nop [2] = '{2, 3};
    logic [7:0] dcode [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    always #5 clk = ~clk;

    ps2_operand_entry u_a (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code), .ack(ack),
        .operands(ops_a), .op_idx(idx_a), .digit_count(cnt_a), .done(done_a), .overflow(ov_a)
    );

    ps2_operand_entry #(.NUM_DIGITS(8), .NUM_OPERANDS(3)) u_b (
        .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code), .ack(ack),
        .operands(ops_b), .op_idx(idx_b), .digit_count(cnt_b), .done(done_b), .overflow(ov_b)
    );

    task automatic model_clear(input int k);
        for (int i = 0; i < 4; i++) mval[k][i] = '0;
        mcnt[k] = 0;
        midx[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            mheld[k] = 0;
            mpre[k] = 0;
            mdone[k] = 0;
            mov[k] = 0;
        end
    endtask

    task automatic model_key(input int k, input logic [7:0] b);
        int d = -1;
        for (int j = 0; j < 10; j++) if (b == dcode[j]) d = j;
        if (d >= 0) begin
            if (mcnt[k] < nd[k]) begin
                mval[k][midx[k]] = mval[k][midx[k]] * 16 + 32'(d);
                mcnt[k]++;
            end else mov[k] = 1;
        end else if (b == 8'h66) begin
            if (mcnt[k] > 0) begin
                mval[k][midx[k]] = mval[k][midx[k]] / 16;
                mcnt[k]--;
            end
        end else if (b == 8'h5A) begin
            if (mcnt[k] > 0) begin
                if (midx[k] == nop[k] - 1) mdone[k] = 1;
                else begin
                    midx[k]++;
                    mcnt[k] = 0;
                end
            end
        end else if (b == 8'h76) model_clear(k);
    endtask

    // mpre: 0 = no prefix pending, 1 = after E0, 2 = after F0
    task automatic model_byte(input logic [7:0] b, input bit a);
        for (int k = 0; k < 2; k++) begin
            bit was_done = mdone[k];
            mov[k] = 0;
            if (a && was_done) begin
                model_clear(k);
                mdone[k] = 0;
            end
            if (mpre[k] == 2) begin
                if (int'(b) == mheld[k]) mheld[k] = 0;
                mpre[k] = 0;
            end else if (b == 8'hF0) mpre[k] = 2;
            else if (mpre[k] == 1) mpre[k] = 0;
            else if (b == 8'hE0) mpre[k] = 1;
            else if (int'(b) != mheld[k]) begin
                mheld[k] = int'(b);
                if (!was_done) model_key(k, b);
            end
        end
    endtask

    function automatic logic [127:0] eops(input int k);
        logic [127:0] v = '0;
        for (int i = nop[k] - 1; i >= 0; i--) v = (v << (4 * nd[k])) | 128'(mval[k][i]);
        return v;
    endfunction

    function automatic logic [145:0] expv(input int k);
        return {eops(k), 8'(midx[k]), 8'(mcnt[k]), mdone[k], mov[k]};
    endfunction

    function automatic logic [145:0] obs(input int k);
        return k == 0 ? {96'b0, ops_a, 7'b0, idx_a, 5'b0, cnt_a, done_a, ov_a}
                      : {32'b0, ops_b, 6'b0, idx_b, 4'b0, cnt_b, done_b, ov_b};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit a);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_code = b;
        ack = a;
        model_byte(b, a);
        @(negedge clk);
        scan_valid = 1'b0;
        ack = 1'b0;
        if (ov_a) ov_cnt++;
    endtask

    task automatic press(input logic [7:0] b);
        send_byte(b, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(b, 1'b0);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs(k) !== '0) begin
                failed++;
                $display("FAIL reset inst%0d got %h exp 0", k, obs(k));
            end
        end
    endtask

    task automatic test_basic();
        press(8'h16);
        press(8'h1E);
        press(8'h5A);
        tests++;
        if ({ops_a[15:0], idx_a, cnt_a, done_a} !== {16'h0012, 1'b1, 3'd0, 1'b0}) begin
            failed++;
            $display("FAIL basic got op0=%h idx=%0d cnt=%0d done=%b exp op0=0012 idx=1 cnt=0 done=0",
                     ops_a[15:0], idx_a, cnt_a, done_a);
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs(k) !== expv(k)) begin
                failed++;
                $display("FAIL basic_model inst%0d got %h exp %h", k, obs(k), expv(k));
            end
        end
        press(8'h76);
    endtask

    task automatic test_repeat();
        send_byte(8'h16, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'h16, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h16, 1'b0);
        tests++;
        if ({ops_a, cnt_a} !== {32'h0000_0001, 3'd1}) begin
            failed++;
            $display("FAIL repeat got ops=%h cnt=%0d exp ops=00000001 cnt=1", ops_a, cnt_a);
        end
        press(8'h76);
    endtask

    task automatic test_overflow();
        ov_cnt = 0;
        foreach (dcode[j]) if (j >= 1 && j <= 5) press(dcode[j]);
        tests++;
        if ({ops_a[15:0], cnt_a} !== {16'h1234, 3'd4}) begin
            failed++;
            $display("FAIL overflow_value got op0=%h cnt=%0d exp op0=1234 cnt=4", ops_a[15:0], cnt_a);
        end
        tests++;
        if (ov_cnt !== 1) begin
            failed++;
            $display("FAIL overflow_pulses got %0d exp 1", ov_cnt);
        end
        tests++;
        if (ops_b[31:0] !== 32'h0001_2345) begin
            failed++;
            $display("FAIL overflow_wide got %h exp 00012345", ops_b[31:0]);
        end
        press(8'h76);
    endtask

    task automatic test_edit();
        press(8'h16);
        press(8'h1E);
        press(8'h66);
        press(8'h26);
        tests++;
        if (ops_a[15:0] !== 16'h0013) begin
            failed++;
            $display("FAIL bksp got %h exp 0013", ops_a[15:0]);
        end
        press(8'h76);
        repeat (3) press(8'h66);
        press(8'h5A);
        tests++;
        if ({idx_a, cnt_a, ops_a} !== {1'b0, 3'd0, 32'h0}) begin
            failed++;
            $display("FAIL empty_edit got idx=%0d cnt=%0d ops=%h exp 0 0 0", idx_a, cnt_a, ops_a);
        end
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs(k) !== expv(k)) begin
                failed++;
                $display("FAIL edit_model inst%0d got %h exp %h", k, obs(k), expv(k));
            end
        end
    endtask

    task automatic test_done_ack();
        press(8'h3D);
        press(8'h5A);
        press(8'h46);
        press(8'h5A);
        tests++;
        if ({done_a, ops_a} !== {1'b1, 32'h0009_0007}) begin
            failed++;
            $display("FAIL done got done=%b ops=%h exp 1 00090007", done_a, ops_a);
        end
        press(8'h26);
        press(8'h5A);
        tests++;
        if ({done_a, ops_a, done_b, ops_b} !== {1'b1, 32'h0009_0007, 1'b1, 96'h3_0000_0009_0000_0007}) begin
            failed++;
            $display("FAIL frozen got a=%b/%h b=%b/%h exp 1/00090007 1/000000030000000900000007",
                     done_a, ops_a, done_b, ops_b);
        end
        send_byte(8'h16, 1'b1);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h16, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tests++;
            if (obs(k) !== '0 || expv(k) !== '0) begin
                failed++;
                $display("FAIL ack inst%0d got %h exp 0", k, obs(k));
            end
        end
    endtask

    task automatic test_async_reset();
        send_byte(8'hF0, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        tests++;
        if (obs(0) !== '0) begin
            failed++;
            $display("FAIL async_rst got %h exp 0", obs(0));
        end
        @(negedge clk);
        rst = 1'b0;
        press(8'h45);
        tests++;
        if ({ops_a, cnt_a} !== {32'h0, 3'd1}) begin
            failed++;
            $display("FAIL post_rst got ops=%h cnt=%0d exp 0 1", ops_a, cnt_a);
        end
        send_byte(8'hE0, 1'b0);
        send_byte(8'h5A, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h5A, 1'b0);
        tests++;
        if ({idx_a, cnt_a, done_a} !== {1'b0, 3'd1, 1'b0}) begin
            failed++;
            $display("FAIL ext_key got idx=%0d cnt=%0d done=%b exp 0 1 0", idx_a, cnt_a, done_a);
        end
        press(8'h76);
    endtask

    task automatic test_random();
        for (int n = 0; n < 800; n++) begin
            int r = $urandom_range(0, 19);
            logic [7:0] b;
            b = r < 10 ? dcode[r] : r < 13 ? 8'hF0 : r == 13 ? 8'hE0 : r < 16 ? 8'h5A :
                r == 16 ? 8'h66 : r == 17 ? 8'h76 : 8'($urandom);
            send_byte(b, $urandom_range(0, 7) == 0);
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (obs(k) !== expv(k)) begin
                    failed++;
                    $display("FAIL random n=%0d byte=%h inst%0d got %h exp %h", n, b, k, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        scan_valid = 1'b0;
        scan_code = '0;
        ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_repeat();
        test_overflow();
        test_edit();
        test_done_ack();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
